// File: rtl/comparador_serial_izq_pkg.sv
// Shared definitions for the MSB-first serial comparator: FSM state encoding
// and a constant-evaluable ceiling log2 used to size the bit counter.
package comparador_serial_izq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } estado_t;

   function automatic int clog2(input int valor);
      int r;
      r = 0;
      while ((1 << r) < valor) r++;
      return r;
   endfunction

endpackage

// File: rtl/celda_serial_izq.sv
// One-bit sticky decision cell: once gt/lt is set it holds, otherwise the
// current bit pair (a, b) decides. Built from inverter/AND/OR gates.
module celda_serial_izq (
   input  logic gt_in,
   input  logic lt_in,
   input  logic a,
   input  logic b,
   output logic gt_out,
   output logic lt_out
);

   logic na;
   logic nb;
   logic ngt;
   logic nlt;
   logic indeciso;
   logic gana;
   logic pierde;

   not inversor_a  (na,  a);
   not inversor_b  (nb,  b);
   not inversor_gt (ngt, gt_in);
   not inversor_lt (nlt, lt_in);

   // Only an undecided chain may be moved by the current bit pair.
   and comp_and_ind (indeciso, ngt, nlt);
   and comp_and_gt  (gana,   indeciso, a,  nb);
   and comp_and_lt  (pierde, indeciso, na, b);

   or  comp_or_gt (gt_out, gt_in, gana);
   or  comp_or_lt (lt_out, lt_in, pierde);

endmodule

// File: rtl/comparador_serial_izq.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// Optional macro EARLY_EXIT_EN: leave SCAN as soon as the decision is made.
module comparador_serial_izq
   import comparador_serial_izq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         W,
   output logic         E,
   output logic         L
);

   localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

   estado_t          estado;
   logic [N-1:0]     a_r;
   logic [N-1:0]     b_r;
   logic [CNT_W-1:0] cnt;
   logic             gt;
   logic             lt;
   logic             gt_nx;
   logic             lt_nx;
   logic             fin_scan;

   celda_serial_izq u_celda (
      .gt_in  (gt),
      .lt_in  (lt),
      .a      (a_r[N-1]),
      .b      (b_r[N-1]),
      .gt_out (gt_nx),
      .lt_out (lt_nx)
   );

`ifdef EARLY_EXIT_EN
   assign fin_scan = (cnt == '0) || gt_nx || lt_nx;
`else
   assign fin_scan = (cnt == '0);
`endif

   // Flags are loaded from the cell outputs on the SCAN->DONE edge so they
   // are already valid in the cycle where done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= ST_IDLE;
         a_r    <= '0;
         b_r    <= '0;
         cnt    <= '0;
         gt     <= 1'b0;
         lt     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         W      <= 1'b0;
         E      <= 1'b0;
         L      <= 1'b0;
      end else begin
         case (estado)
            ST_IDLE: begin
               if (start) begin
                  a_r    <= A;
                  b_r    <= B;
                  cnt    <= CNT_W'(N - 1);
                  gt     <= 1'b0;
                  lt     <= 1'b0;
                  W      <= 1'b0;
                  E      <= 1'b0;
                  L      <= 1'b0;
                  busy   <= 1'b1;
                  estado <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               gt  <= gt_nx;
               lt  <= lt_nx;
               a_r <= a_r << 1;
               b_r <= b_r << 1;
               cnt <= cnt - CNT_W'(1);
               if (fin_scan) begin
                  W      <= gt_nx;
                  E      <= ~gt_nx & ~lt_nx;
                  L      <= lt_nx;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  estado <= ST_DONE;
               end
            end
            ST_DONE: begin
               done   <= 1'b0;
               estado <= ST_IDLE;
            end
            default: begin
               busy   <= 1'b0;
               done   <= 1'b0;
               estado <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparador_serial_izq.sv
// Directed self-checking bench for comparador_serial_izq (N=8), covering
// both builds with and without EARLY_EXIT_EN.
module tb_comparador_serial_izq;

   localparam logic [2:0] WEL_W = 3'b100;
   localparam logic [2:0] WEL_E = 3'b010;
   localparam logic [2:0] WEL_L = 3'b001;

`ifdef EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy;
   logic       done;
   logic       W;
   logic       E;
   logic       L;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc = 0;

   comparador_serial_izq #(.N(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .W     (W),
      .E     (E),
      .L     (L)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; raises start and follows one comparison until done.
   task automatic do_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int lat_exp, input logic [2:0] wel_exp, input bit hold);
      bit seen;
      bit got;
      int j;
      int nbusy;
      start = 1'b1;
      A = a;
      B = b;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy) begin
            seen = 1'b1;
            break;
         end
      end
      comprobar({tag, "_acepta"}, 32'(seen), 32'd1);
      if (!seen) begin
         start = 1'b0;
         return;
      end
      last_acc = cyc;
      comprobar({tag, "_wel_borrado"}, 32'({W, E, L}), 32'd0);
      if (hold) begin
         A = 8'h00;
         B = 8'hFF;
      end else begin
         start = 1'b0;
      end
      j = 1;
      nbusy = 1;
      got = 1'b0;
      while (j < 20 && !got) begin
         @(negedge clk);
         j++;
         if (busy) nbusy++;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      comprobar({tag, "_latencia"}, got ? 32'(j) : 32'd0, 32'(lat_exp));
      comprobar({tag, "_ciclos_busy"}, 32'(nbusy), 32'(lat_exp - 1));
      comprobar({tag, "_wel"}, 32'({W, E, L}), 32'(wel_exp));
   endtask

   int acc1;
   int ndone;
   int lat;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      A = 8'h00;
      B = 8'h00;
      repeat (3) @(negedge clk);
      comprobar("reset_salidas", 32'({busy, done, W, E, L}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: A > B decided at the MSB
      lat = EE ? 2 : 9;
      do_cmp("t1_a5_5a", 8'hA5, 8'h5A, lat, WEL_W, 1'b0);
      @(negedge clk);
      comprobar("t1_pulso_done", 32'(done), 32'd0);

      // 2: equal operands, flags hold while idle
      do_cmp("t2_3c_3c", 8'h3C, 8'h3C, 9, WEL_E, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         comprobar("t2_retencion", 32'({done, W, E, L}), 32'({1'b0, WEL_E}));
      end

      // 3: back-to-back starts, period N+2 without early exit
      lat = EE ? 2 : 9;
      do_cmp("t3_00_ff", 8'h00, 8'hFF, lat, WEL_L, 1'b0);
      acc1 = last_acc;
      do_cmp("t3_ff_fe", 8'hFF, 8'hFE, 9, WEL_W, 1'b0);
      comprobar("t3_periodo", 32'(last_acc - acc1), 32'(lat + 1));

      // 4: start held and operands changed during SCAN
      @(negedge clk);
      lat = EE ? 5 : 9;
      do_cmp("t4_10_01", 8'h10, 8'h01, lat, WEL_W, 1'b1);
      @(negedge clk);
      comprobar("t4_un_solo_done", 32'({done, busy}), 32'd0);

      // 5: reset on the 4th SCAN cycle aborts the comparison
      start = 1'b1;
      A = 8'h55;
      B = 8'h55;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      comprobar("t5_busy_antes_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      comprobar("t5_tras_rst", 32'({busy, done, W, E, L}), 32'd0);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      comprobar("t5_sin_actividad", 32'(ndone), 32'd0);
      lat = EE ? 8 : 9;
      do_cmp("t5_01_02", 8'h01, 8'h02, lat, WEL_L, 1'b0);

      // 6: vectors whose latency depends on the early-exit build
      @(negedge clk);
      lat = EE ? 2 : 9;
      do_cmp("t6_80_00", 8'h80, 8'h00, lat, WEL_W, 1'b0);
      @(negedge clk);
      do_cmp("t6_01_00", 8'h01, 8'h00, 9, WEL_W, 1'b0);
      @(negedge clk);
      do_cmp("t6_77_77", 8'h77, 8'h77, 9, WEL_E, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
